// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit:
// operation and FSM state encodings plus the iteration count.
package mips_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdOp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } mdState_t;

  localparam int unsigned MD_ITER = 32;

endpackage

// File: rtl/md_sign_adjust.sv
// Combinational sign handling: operand magnitudes and result signs at accept,
// conditional negation of the unsigned accumulator result at finish.
module md_sign_adjust
  import mips_pkg::*;
(
  input  mdOp_t       op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        neg_main,
  output logic        neg_rem,
  input  logic        is_div,
  input  logic        neg_main_q,
  input  logic        neg_rem_q,
  input  logic [63:0] acc,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic is_signed;

  always_comb begin
    is_signed = (op == MULT) || (op == DIV);
    mag_a     = (is_signed && src_a[31]) ? -src_a : src_a;
    mag_b     = (is_signed && src_b[31]) ? -src_b : src_b;
    // Product and quotient share one sign; the remainder follows the dividend.
    neg_main  = is_signed && (src_a[31] ^ src_b[31]);
    neg_rem   = is_signed && (op == DIV) && src_a[31];

    if (is_div) begin
      res_lo = neg_main_q ? -acc[31:0]  : acc[31:0];
      res_hi = neg_rem_q  ? -acc[63:32] : acc[63:32];
    end else begin
      {res_hi, res_lo} = neg_main_q ? -acc : acc;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: one radix-2 step per cycle over a
// shared 64-bit accumulator, plus MTHI/MTLO moves while idle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdState_t         state, state_nxt;
  mdOp_t            op_q;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0] opnd, a_q, hi_q, lo_q;
  logic [4:0]       cnt;
  logic             div_zero, neg_main_q, neg_rem_q, done_q;

  logic [WIDTH-1:0] mag_a, mag_b, res_hi, res_lo;
  logic             neg_main, neg_rem, in_div, is_div;
  logic [WIDTH:0]   sum, diff;

  assign in_div = (mdOp_t'(mdOp) == DIV) || (mdOp_t'(mdOp) == DIVU);
  assign is_div = (op_q == DIV) || (op_q == DIVU);

  md_sign_adjust u_sign (
    .op         (mdOp_t'(mdOp)),
    .src_a      (srcA),
    .src_b      (srcB),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .neg_main   (neg_main),
    .neg_rem    (neg_rem),
    .is_div     (is_div),
    .neg_main_q (neg_main_q),
    .neg_rem_q  (neg_rem_q),
    .acc        (acc),
    .res_hi     (res_hi),
    .res_lo     (res_lo)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 5'(MD_ITER - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divide compares the 33-bit {remainder, next dividend bit} so a remainder
  // with its top bit set still subtracts correctly.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, opnd};
    diff     = acc[63:31] - {1'b0, opnd};
    acc_step = acc;
    if (is_div) begin
      if (!diff[WIDTH]) acc_step = {diff[31:0], acc[30:0], 1'b1};
      else              acc_step = {acc[62:0], 1'b0};
    end else if (acc[0]) begin
      acc_step = {sum, acc[31:1]};
    end else begin
      acc_step = {1'b0, acc[63:1]};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      op_q       <= MULT;
      acc        <= '0;
      opnd       <= '0;
      a_q        <= '0;
      cnt        <= '0;
      div_zero   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= mdOp_t'(mdOp);
            acc        <= {{WIDTH{1'b0}}, in_div ? mag_a : mag_b};
            opnd       <= in_div ? mag_b : mag_a;
            a_q        <= srcA;
            cnt        <= '0;
            div_zero   <= in_div && (srcB == '0);
            neg_main_q <= neg_main;
            neg_rem_q  <= neg_rem;
          end else begin
            if (hiWrite) hi_q <= wrData;
            if (loWrite) lo_q <= wrData;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
        end
        FINISH: begin
          if (div_zero) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
